store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-queue entries (power of two, >=2).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  pipeline request handshake; transfer when both high at clk edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr/req_wdata  in  32/32  byte address / store data.
REQ-008 req_sign_mask  in  4  [3] sign-extend, [2:1] size: 00 byte, 01 half, 11 word.
REQ-009 resp_valid/resp_rdata  out  1/32  one-cycle load-result pulse and data.
REQ-010 mem_addr/mem_write_data/mem_sign_mask  out  32/32/4  to data memory, stable from ISSUE until WAIT_LO exits.
REQ-011 mem_memwrite/mem_memread  out  1/1  one-cycle issue pulses.
REQ-012 mem_read_data/mem_clk_stall  in  32/1  data memory result and busy flag.

Function
REQ-013 Stores SHALL enqueue in the FIFO when req_ready; req_ready for stores = !full (a same-cycle dequeue does not free a slot).
REQ-014 One load SHALL be held in a load register; req_ready for loads = no load pending and FSM not completing a load.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-016 IDLE->ISSUE when FIFO non-empty (head store selected) or, FIFO empty, a load is pending; stores always drain before the pending load.
REQ-017 ISSUE SHALL assert exactly one of mem_memwrite/mem_memread for one cycle, then ->WAIT_HI.
REQ-018 WAIT_HI->WAIT_LO when mem_clk_stall==1; WAIT_LO->IDLE when mem_clk_stall==0.
REQ-019 On WAIT_LO exit: store -> FIFO head popped; load -> resp_valid=1, resp_rdata=mem_read_data for that one cycle.
REQ-020 Minimum store drain SHALL be 4 cycles per entry; load with empty FIFO: resp_valid 4 cycles after acceptance edge.
REQ-021 Pointers SHALL wrap modulo DEPTH; full/empty from a DEPTH+1-value count.
REQ-022 Accept of a new store while a store drains SHALL not disturb mem_* outputs.
REQ-023 resp_valid SHALL never assert for stores.

Reset
REQ-024 rst_n low SHALL asynchronously force: FSM IDLE, FIFO empty, no load pending, resp_valid 0, resp_rdata 0, mem_memread/mem_memwrite 0, mem_addr/mem_write_data/mem_sign_mask 0; req_ready 1 after release.
REQ-025 Reset mid-transaction SHALL discard all queued stores and the pending load; no response is produced.

Configuration
REQ-026 Macro STORE_BUFFER_FWD_EN SHALL enable load forwarding: word load (size 11) whose addr[31:2] matches the youngest matching entry holding a word store SHALL respond resp_valid next cycle with that data, no memory access.
REQ-027 Match on non-word store or non-word load SHALL fall back to REQ-016 ordering.
REQ-028 Without the macro, loads SHALL always wait for FIFO empty; no comparators synthesized.

Structure
REQ-029 Package dmem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state typedef, default DEPTH.
REQ-030 FIFO storage SHALL be sub-module sb_fifo (push, pop, full, empty, head, plus entry-array read ports for forwarding).

Verification
REQ-031 Reset, then store word 0xDEADBEEF @0x10 -> mem_memwrite pulse one cycle later, mem_addr 0x10, FIFO empty after WAIT_LO.
REQ-032 Stall-model responder; 5 back-to-back stores -> 4 accepted, req_ready low until first pop, in-order memory writes.
REQ-033 Store 0x11223344 @0x20, load word @0x20 -> with macro resp_rdata 0x11223344 next cycle, no mem_memread; without, returned after store drains.
REQ-034 Store byte 0x80 @0x21, load byte signed @0x21 -> no forwarding; response 0xFFFFFF80 after store.
REQ-035 rst_n low during WAIT_HI with 3 queued stores -> all outputs 0 immediately, no further mem pulses, no resp_valid.
REQ-036 Load with empty FIFO, mem_read_data 0xCAFEF00D -> resp_valid exactly once, 4 cycles after acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the store buffer: access-size encodings, FSM state, queue entry layout.
package dmem_pkg;

   localparam int DEFAULT_DEPTH = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } sb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sign_mask;
   } sb_entry_t;

   // sign_mask[2:1] carries the access size
   function automatic logic is_word(input logic [3:0] sign_mask);
      return sign_mask[2:1] == SZ_WORD;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline request/response channel and data-memory port of the store buffer.
interface store_buffer_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_sign_mask;

   logic        resp_valid;
   logic [31:0] resp_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memwrite;
   logic        mem_memread;
   logic [31:0] mem_read_data;
   logic        mem_clk_stall;

   // master: pipeline plus data memory; slave: the store buffer
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_sign_mask,
      input  req_ready, resp_valid, resp_rdata,
      input  mem_addr, mem_write_data, mem_sign_mask, mem_memwrite, mem_memread,
      output mem_read_data, mem_clk_stall
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_sign_mask,
      output req_ready, resp_valid, resp_rdata,
      output mem_addr, mem_write_data, mem_sign_mask, mem_memwrite, mem_memread,
      input  mem_read_data, mem_clk_stall
   );

endinterface

// File: rtl/sb_fifo.sv
// Store-queue FIFO; pointers wrap by width (DEPTH is a power of two), occupancy from a DEPTH+1-value count.
// With STORE_BUFFER_FWD_EN the whole entry array, head index and occupancy are exported for forwarding.
module sb_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  sb_entry_t     push_entry,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output sb_entry_t     head
`ifdef STORE_BUFFER_FWD_EN
   ,
   output sb_entry_t     entries [DEPTH],
   output logic [PW-1:0] head_idx,
   output logic [CW-1:0] occupancy
`endif
);

   sb_entry_t     slots [DEPTH];
   logic [PW-1:0] rd_idx;
   logic [PW-1:0] wr_idx;
   logic [CW-1:0] fill;
   logic          do_push;
   logic          do_pop;

   assign full    = (fill == CW'(DEPTH));
   assign empty   = (fill == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = slots[rd_idx];

`ifdef STORE_BUFFER_FWD_EN
   assign entries   = slots;
   assign head_idx  = rd_idx;
   assign occupancy = fill;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx <= '0;
         wr_idx <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_idx <= wr_idx + 1'b1;
         if (do_pop)  rd_idx <= rd_idx + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // storage needs no reset: fill alone says which slots are live
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_idx] <= push_entry;
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues stores, holds one load, and runs the data-memory stall handshake.
// Define STORE_BUFFER_FWD_EN to forward a queued word store to a matching word load.
//
// state   | meaning
// IDLE    | pick next access: head store first, pending load only when queue is empty
// ISSUE   | one-cycle mem_memwrite or mem_memread pulse
// WAIT_HI | wait for memory to raise mem_clk_stall
// WAIT_LO | wait for stall to drop; retire store or return load data
module store_buffer
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic           clk,
   input logic           rst_n,
   store_buffer_if.slave bus
);

   sb_state_t   state;
   logic        cur_load;
   logic        load_pending;
   logic [31:0] ld_addr;
   logic [3:0]  ld_mask;

   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_write_data_r;
   logic [3:0]  mem_sign_mask_r;
   logic        mem_memwrite_r;
   logic        mem_memread_r;

   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic        store_acc;
   logic        load_acc;
   sb_entry_t   head;
   sb_entry_t   new_entry;

   // load_pending stays set until the response cycle, so this also covers a completing load
   assign bus.req_ready = bus.req_we ? !fifo_full : !load_pending;
   assign store_acc     = bus.req_valid && bus.req_ready && bus.req_we;
   assign load_acc      = bus.req_valid && bus.req_ready && !bus.req_we;
   assign fifo_pop      = (state == WAIT_LO) && !bus.mem_clk_stall && !cur_load;

   assign new_entry = '{addr: bus.req_addr, data: bus.req_wdata, sign_mask: bus.req_sign_mask};

`ifdef STORE_BUFFER_FWD_EN
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   sb_entry_t     entries [DEPTH];
   logic [PW-1:0] head_idx;
   logic [CW-1:0] occupancy;
   logic [PW-1:0] idx;
   logic          fwd_hit;
   logic [31:0]   fwd_data;

   // scan oldest to youngest so the last match wins; a non-word youngest match blocks forwarding
   always_comb begin
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_idx + PW'(i);
         if (CW'(i) < occupancy && entries[idx].addr[31:2] == bus.req_addr[31:2]) begin
            fwd_hit  = is_word(entries[idx].sign_mask);
            fwd_data = entries[idx].data;
         end
      end
      fwd_hit = fwd_hit && is_word(bus.req_sign_mask);
   end
`endif

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (store_acc),
      .push_entry (new_entry),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head)
`ifdef STORE_BUFFER_FWD_EN
      ,
      .entries    (entries),
      .head_idx   (head_idx),
      .occupancy  (occupancy)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cur_load         <= 1'b0;
         load_pending     <= 1'b0;
         ld_addr          <= '0;
         ld_mask          <= '0;
         resp_valid_r     <= 1'b0;
         resp_rdata_r     <= '0;
         mem_addr_r       <= '0;
         mem_write_data_r <= '0;
         mem_sign_mask_r  <= '0;
         mem_memwrite_r   <= 1'b0;
         mem_memread_r    <= 1'b0;
      end else begin
         resp_valid_r   <= 1'b0;
         mem_memwrite_r <= 1'b0;
         mem_memread_r  <= 1'b0;

         if (load_acc) begin
`ifdef STORE_BUFFER_FWD_EN
            if (fwd_hit) begin
               resp_valid_r <= 1'b1;
               resp_rdata_r <= fwd_data;
            end else
`endif
            begin
               load_pending <= 1'b1;
               ld_addr      <= bus.req_addr;
               ld_mask      <= bus.req_sign_mask;
            end
         end

         // mem_* address/data only change on IDLE->ISSUE, so a store accepted mid-drain is invisible
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state            <= ISSUE;
                  cur_load         <= 1'b0;
                  mem_memwrite_r   <= 1'b1;
                  mem_addr_r       <= head.addr;
                  mem_write_data_r <= head.data;
                  mem_sign_mask_r  <= head.sign_mask;
               end else if (load_pending) begin
                  state            <= ISSUE;
                  cur_load         <= 1'b1;
                  mem_memread_r    <= 1'b1;
                  mem_addr_r       <= ld_addr;
                  mem_write_data_r <= '0;
                  mem_sign_mask_r  <= ld_mask;
               end
            end
            ISSUE: state <= WAIT_HI;
            WAIT_HI: begin
               if (bus.mem_clk_stall) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!bus.mem_clk_stall) begin
                  state <= IDLE;
                  if (cur_load) begin
                     resp_valid_r <= 1'b1;
                     resp_rdata_r <= bus.mem_read_data;
                     load_pending <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.resp_valid     = resp_valid_r;
   assign bus.resp_rdata     = resp_rdata_r;
   assign bus.mem_addr       = mem_addr_r;
   assign bus.mem_write_data = mem_write_data_r;
   assign bus.mem_sign_mask  = mem_sign_mask_r;
   assign bus.mem_memwrite   = mem_memwrite_r;
   assign bus.mem_memread    = mem_memread_r;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: byte memory with a one-cycle stall responder, table of store/load pairs.
`timescale 1ns/1ps
module tb_store_buffer;
   import dmem_pkg::*;

`ifdef STORE_BUFFER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   store_buffer_if sb_if ();

   store_buffer #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [0:255];
   logic        pend = 1'b0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          resp_cnt = 0;
   logic [31:0] wr_log [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int n;
      n = (m[2:1] == 2'b00) ? 1 : (m[2:1] == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) mem[8'(a + 32'(k))] = d[8*k +: 8];
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [3:0] m);
      logic [31:0] v;
      v = '0;
      case (m[2:1])
         2'b00: begin
            v[7:0] = mem[8'(a)];
            if (m[3]) v = {{24{v[7]}}, v[7:0]};
         end
         2'b01: begin
            v[15:0] = {mem[8'(a + 32'd1)], mem[8'(a)]};
            if (m[3]) v = {{16{v[15]}}, v[15:0]};
         end
         default: v = {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[8'(a)]};
      endcase
      return v;
   endfunction

   // memory responder: stall goes high the cycle after an issue pulse, low the cycle after that
   always @(negedge clk) begin
      if (!rst_n) begin
         pend                = 1'b0;
         sb_if.mem_clk_stall = 1'b0;
         sb_if.mem_read_data = '0;
      end else begin
         sb_if.mem_clk_stall = pend;
         pend = sb_if.mem_memread | sb_if.mem_memwrite;
         if (sb_if.mem_memwrite) begin
            wr_cnt++;
            wr_log.push_back(sb_if.mem_addr);
            mem_wr(sb_if.mem_addr, sb_if.mem_write_data, sb_if.mem_sign_mask);
         end
         if (sb_if.mem_memread) begin
            rd_cnt++;
            sb_if.mem_read_data = mem_rd(sb_if.mem_addr, sb_if.mem_sign_mask);
         end
         if (sb_if.resp_valid) resp_cnt++;
      end
   end

   task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output int waited);
      int w;
      w = 0;
      @(negedge clk);
      sb_if.req_we        = we;
      sb_if.req_addr      = a;
      sb_if.req_wdata     = d;
      sb_if.req_sign_mask = m;
      sb_if.req_valid     = 1'b1;
      #1;
      while (!sb_if.req_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!sb_if.req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: req_ready=0 required=1 addr=%h", a);
      end else begin
         @(posedge clk);
      end
      #1 sb_if.req_valid = 1'b0;
      waited = w;
   endtask

   task automatic wait_resp(input int limit, output logic got, output int lat, output logic [31:0] data);
      got  = 1'b0;
      lat  = 0;
      data = '0;
      for (int k = 1; k <= limit && !got; k++) begin
         @(negedge clk);
         if (sb_if.resp_valid) begin
            got  = 1'b1;
            lat  = k;
            data = sb_if.resp_rdata;
         end
      end
   endtask

   task automatic do_load(input string name, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] exp, input logic exp_fwd);
      int          w;
      int          rd0;
      int          lat;
      logic        got;
      logic [31:0] data;
      rd0 = rd_cnt;
      send(1'b0, a, 32'h0, m, w);
      wait_resp(40, got, lat, data);
      check({name, "_got"}, 32'(got), 32'd1);
      check({name, "_data"}, data, exp);
      check({name, "_fwd"}, 32'(lat == 1), 32'(exp_fwd));
      repeat (12) @(negedge clk);
      check({name, "_memread"}, 32'(rd_cnt - rd0), exp_fwd ? 32'd0 : 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic [3:0]  st_mask;
      logic [31:0] ld_addr;
      logic [3:0]  ld_mask;
      logic [31:0] exp_rdata;
      logic        fwd_ok;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int w;
      int c_wr;
      int c_rd;
      int c_resp;

      vecs[0] = '{"word_fwd",   32'h20, 32'h11223344, 4'b0110, 32'h20, 4'b0110, 32'h11223344, 1'b1};
      vecs[1] = '{"byte_sext",  32'h21, 32'h00000080, 4'b0000, 32'h21, 4'b1000, 32'hFFFFFF80, 1'b0};
      vecs[2] = '{"half_uns",   32'h32, 32'h0000BEEF, 4'b0010, 32'h32, 4'b0010, 32'h0000BEEF, 1'b0};
      vecs[3] = '{"byte_ld_w",  32'h44, 32'hA5A50001, 4'b0110, 32'h44, 4'b0000, 32'h00000001, 1'b0};
      vecs[4] = '{"other_word", 32'h50, 32'h12345678, 4'b0110, 32'h54, 4'b0110, 32'h00000000, 1'b0};
      vecs[5] = '{"signed_wd",  32'h60, 32'h0BADF00D, 4'b0110, 32'h60, 4'b1110, 32'h0BADF00D, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h40] = 8'h0D;
      mem[8'h41] = 8'hF0;
      mem[8'h42] = 8'hFE;
      mem[8'h43] = 8'hCA;

      sb_if.req_valid     = 1'b0;
      sb_if.req_we        = 1'b1;
      sb_if.req_addr      = '0;
      sb_if.req_wdata     = '0;
      sb_if.req_sign_mask = '0;
      rst_n = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_resp_valid", 32'(sb_if.resp_valid), 32'd0);
      check("rst_resp_rdata", sb_if.resp_rdata, 32'd0);
      check("rst_memwrite", 32'(sb_if.mem_memwrite), 32'd0);
      check("rst_memread", 32'(sb_if.mem_memread), 32'd0);
      check("rst_mem_addr", sb_if.mem_addr, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready_store", 32'(sb_if.req_ready), 32'd1);
      sb_if.req_we = 1'b0;
      #1;
      check("rst_ready_load", 32'(sb_if.req_ready), 32'd1);

      // single store: pulse one cycle after acceptance, queue empty after WAIT_LO
      send(1'b1, 32'h10, 32'hDEADBEEF, 4'b0110, w);
      @(negedge clk);
      check("st_pulse_early", 32'(sb_if.mem_memwrite), 32'd0);
      @(negedge clk);
      check("st_pulse", 32'(sb_if.mem_memwrite), 32'd1);
      check("st_addr", sb_if.mem_addr, 32'h10);
      check("st_wdata", sb_if.mem_write_data, 32'hDEADBEEF);
      check("st_mask", 32'(sb_if.mem_sign_mask), 32'h6);
      @(negedge clk);
      check("st_pulse_once", 32'(sb_if.mem_memwrite), 32'd0);
      check("st_addr_hold", sb_if.mem_addr, 32'h10);
      @(negedge clk);
      check("st_not_yet_empty", 32'(dut.u_fifo.empty), 32'd0);
      @(negedge clk);
      check("st_empty", 32'(dut.u_fifo.empty), 32'd1);
      repeat (3) @(negedge clk);

      // load with empty queue: response exactly on the fourth edge after acceptance
      c_resp = resp_cnt;
      send(1'b0, 32'h40, 32'h0, 4'b0110, w);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         check($sformatf("ld_resp_n%0d", n), 32'(sb_if.resp_valid), 32'(n == 5));
         if (n == 5) check("ld_rdata", sb_if.resp_rdata, 32'hCAFEF00D);
      end
      check("ld_resp_count", 32'(resp_cnt - c_resp), 32'd1);
      repeat (3) @(negedge clk);

      // five back-to-back stores into a four-entry queue
      wr_log.delete();
      c_resp = resp_cnt;
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 32'h80 + 32'(4 * i), 32'(i + 1), 4'b0110, w);
         check($sformatf("bb_wait%0d", i), 32'(w), (i == 4) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 100 && wr_log.size() < 5; k++) @(negedge clk);
      repeat (6) @(negedge clk);
      check("bb_wr_count", 32'(wr_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < wr_log.size())
            check($sformatf("bb_wr_addr%0d", i), wr_log[i], 32'h80 + 32'(4 * i));
      end
      check("bb_no_resp", 32'(resp_cnt - c_resp), 32'd0);

      // store/load pairs
      for (int i = 0; i < 6; i++) begin
         send(1'b1, vecs[i].st_addr, vecs[i].st_data, vecs[i].st_mask, w);
         do_load(vecs[i].name, vecs[i].ld_addr, vecs[i].ld_mask, vecs[i].exp_rdata, vecs[i].fwd_ok && FWD);
      end

      // two word stores to the same word: youngest data wins
      send(1'b1, 32'h70, 32'h00000001, 4'b0110, w);
      send(1'b1, 32'h70, 32'h00000002, 4'b0110, w);
      do_load("youngest", 32'h70, 4'b0110, 32'h00000002, FWD);

      // youngest match is a byte store: no forwarding, memory order applies
      send(1'b1, 32'h74, 32'hAAAAAAAA, 4'b0110, w);
      send(1'b1, 32'h74, 32'h00000055, 4'b0000, w);
      do_load("young_byte", 32'h74, 4'b0110, 32'hAAAAAA55, 1'b0);

      // reset during WAIT_HI with three stores queued
      send(1'b1, 32'hA0, 32'h000000A0, 4'b0110, w);
      send(1'b1, 32'hA4, 32'h000000A4, 4'b0110, w);
      send(1'b1, 32'hA8, 32'h000000A8, 4'b0110, w);
      check("mid_state", 32'(dut.state), 32'(WAIT_HI));
      check("mid_addr", sb_if.mem_addr, 32'hA0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_addr", sb_if.mem_addr, 32'd0);
      check("mid_rst_wdata", sb_if.mem_write_data, 32'd0);
      check("mid_rst_mask", 32'(sb_if.mem_sign_mask), 32'd0);
      check("mid_rst_memwrite", 32'(sb_if.mem_memwrite), 32'd0);
      check("mid_rst_memread", 32'(sb_if.mem_memread), 32'd0);
      check("mid_rst_resp_valid", 32'(sb_if.resp_valid), 32'd0);
      check("mid_rst_rdata", sb_if.resp_rdata, 32'd0);
      check("mid_rst_empty", 32'(dut.u_fifo.empty), 32'd1);
      c_wr   = wr_cnt;
      c_rd   = rd_cnt;
      c_resp = resp_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_writes", 32'(wr_cnt - c_wr), 32'd0);
      check("post_rst_reads", 32'(rd_cnt - c_rd), 32'd0);
      check("post_rst_resp", 32'(resp_cnt - c_resp), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
